// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 response codes and word-address decode helper
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Wide enough for the largest supported array (4096 words).
  localparam int unsigned IDX_W = 12;

  typedef struct packed {
    logic             ok;
    logic [IDX_W-1:0] idx;
  } addr_dec_t;

  // Offset is taken from the base so the upper bound never overflows 32 bits.
  function automatic addr_dec_t addr_decode(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] depth);
    addr_dec_t   d;
    logic [31:0] off;
    off   = addr - base;
    d.ok  = (addr >= base) && ({2'b00, off[31:2]} < depth);
    d.idx = off[IDX_W+1:2];
    return d;
  endfunction

endpackage

// File: rtl/axil_wr_ch.sv
// rtl/axil_wr_ch.sv - AW/W holding registers and B response for the AXI4-Lite RAM
module axil_wr_ch
  import axi4_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [1:0]  ERR_RESP  = 2'b10,
  localparam int unsigned IW       = $clog2(DEPTH)
) (
  input  logic          axilite_clk,
  input  logic          axilite_rstb,
  input  logic          run,
  input  logic [31:0]   awaddr,
  input  logic          awvalid,
  output logic          awready,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          wvalid,
  output logic          wready,
  output logic [1:0]    bresp,
  output logic          bvalid,
  input  logic          bready,
  output logic          mem_we,
  output logic [IW-1:0] mem_idx,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb
);

  logic          aw_full;
  logic          aw_ok;
  logic [IW-1:0] aw_idx;
  logic          w_full;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          commit;
  addr_dec_t     aw_dec;

  assign aw_dec  = addr_decode(awaddr, BASE_ADDR, DEPTH);
  assign awready = run && !aw_full;
  assign wready  = run && !w_full;
  // A pending B blocks the next commit, so responses stay in order.
  assign commit  = aw_full && w_full && !bvalid;

  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) begin
      aw_full <= 1'b0;
      aw_ok   <= 1'b0;
      aw_idx  <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (awvalid && awready) begin
        aw_full <= 1'b1;
        aw_ok   <= aw_dec.ok;
        aw_idx  <= aw_dec.idx[IW-1:0];
      end else if (commit) begin
        aw_full <= 1'b0;
      end

      if (wvalid && wready) begin
        w_full <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end

      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= aw_ok ? RESP_OKAY : ERR_RESP;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  assign mem_we    = commit && aw_ok;
  assign mem_idx   = aw_idx;
  assign mem_wdata = w_data;
  assign mem_wstrb = w_strb;

endmodule

// File: rtl/axil_ram_slave.sv
// rtl/axil_ram_slave.sv - AXI4-Lite responder backed by a DEPTH x 32 register array
module axil_ram_slave
  import axi4_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [1:0]  ERR_RESP  = 2'b10
) (
  input  logic        axilite_clk,
  input  logic        axilite_rstb,
  input  logic [31:0] s_axilite_awaddr,
  input  logic [2:0]  s_axilite_awprot,
  input  logic        s_axilite_awvalid,
  output logic        s_axilite_awready,
  input  logic [31:0] s_axilite_wdata,
  input  logic [3:0]  s_axilite_wstrb,
  input  logic        s_axilite_wvalid,
  output logic        s_axilite_wready,
  output logic [1:0]  s_axilite_bresp,
  output logic        s_axilite_bvalid,
  input  logic        s_axilite_bready,
  input  logic [31:0] s_axilite_araddr,
  input  logic [2:0]  s_axilite_arprot,
  input  logic        s_axilite_arvalid,
  output logic        s_axilite_arready,
  output logic [31:0] s_axilite_rdata,
  output logic [1:0]  s_axilite_rresp,
  output logic        s_axilite_rvalid,
  input  logic        s_axilite_rready
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic          run;
  logic [31:0]   mem [DEPTH];
  logic          mem_we;
  logic [IW-1:0] mem_idx;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  addr_dec_t     ar_dec;

  // Holds every ready low during reset and for the first edge after release.
  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) run <= 1'b0;
    else               run <= 1'b1;
  end

  axil_wr_ch #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH),
    .ERR_RESP  (ERR_RESP)
  ) u_wr_ch (
    .axilite_clk  (axilite_clk),
    .axilite_rstb (axilite_rstb),
    .run          (run),
    .awaddr       (s_axilite_awaddr),
    .awvalid      (s_axilite_awvalid),
    .awready      (s_axilite_awready),
    .wdata        (s_axilite_wdata),
    .wstrb        (s_axilite_wstrb),
    .wvalid       (s_axilite_wvalid),
    .wready       (s_axilite_wready),
    .bresp        (s_axilite_bresp),
    .bvalid       (s_axilite_bvalid),
    .bready       (s_axilite_bready),
    .mem_we       (mem_we),
    .mem_idx      (mem_idx),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb)
  );

  always_ff @(posedge axilite_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign ar_dec            = addr_decode(s_axilite_araddr, BASE_ADDR, DEPTH);
  assign s_axilite_arready = run && !s_axilite_rvalid;

  // Non-blocking read of the array returns pre-write data on a same-edge collision.
  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) begin
      s_axilite_rvalid <= 1'b0;
      s_axilite_rdata  <= '0;
      s_axilite_rresp  <= RESP_OKAY;
    end else if (s_axilite_arvalid && s_axilite_arready) begin
      s_axilite_rvalid <= 1'b1;
      s_axilite_rresp  <= ar_dec.ok ? RESP_OKAY : ERR_RESP;
      s_axilite_rdata  <= ar_dec.ok ? mem[ar_dec.idx[IW-1:0]] : 32'h0;
    end else if (s_axilite_rvalid && s_axilite_rready) begin
      s_axilite_rvalid <= 1'b0;
    end
  end

endmodule

// File: doc/axil_ram_slave.md
AXIL_RAM_SLAVE -- requirements
Module: axil_ram_slave

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0010_0000, byte address of word 0.
REQ-002 Parameter: DEPTH, 1024, number of 32-bit words; power of two, 16..4096.
REQ-003 Parameter: ERR_RESP, 2'b10, response code for out-of-range access (SLVERR).
REQ-004 axilite_clk  in  1  single clock for all logic.
REQ-005 axilite_rstb  in  1  asynchronous active-low reset.
REQ-006 s_axilite  modport-slave  AXI4Lite  AW/W/B/AR/R channels: 32-bit addr, 32-bit data, 4-bit wstrb, 3-bit prot, 2-bit resp.
REQ-007 Clocking and reset are decided: one clock; reset is asynchronous and active-low.

Function
REQ-010 The block SHALL be an AXI4-Lite responder backed by a DEPTH x 32 register array, with independent write and read paths.
REQ-011 Word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] ignored; awprot/arprot ignored.
REQ-012 Address in range SHALL mean BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH; otherwise the access is out of range.
REQ-013 Write path: one-entry AW holding register and one-entry W holding register; awready = AW slot empty, wready = W slot empty.
REQ-014 AW and W SHALL be accepted in either order or the same cycle; no combinational path from valid to ready.
REQ-015 When both slots are full and B is not pending, the array write SHALL occur on that edge, per-byte under wstrb, and bvalid SHALL assert the next cycle with bresp OKAY.
REQ-016 Both slots SHALL clear on that same edge; AW and W may be accepted again while bvalid is high, but no second write commits until bvalid&&bready.
REQ-017 Out-of-range write: array unchanged; bresp = ERR_RESP.
REQ-018 wstrb = 4'b0000 in range: array unchanged; bresp OKAY.
REQ-019 Read path: arready = !rvalid; on arvalid&&arready, rdata is registered from the array and rvalid asserts the next cycle (1-cycle latency).
REQ-020 rvalid, rdata and rresp SHALL hold stable until rready; back-to-back reads SHALL sustain one read every 2 cycles.
REQ-021 Out-of-range read: rdata = 32'h0, rresp = ERR_RESP.
REQ-022 Read and write commit to the same word on the same edge: the read SHALL return the pre-write data.
REQ-023 bvalid and rvalid SHALL never drop without their ready.

Reset
REQ-030 Asserting axilite_rstb low SHALL immediately clear: awready=1, wready=1, arready=1 once deasserted; bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, both holding slots empty.
REQ-031 Array contents are not reset. A transaction in flight at reset is discarded; no B or R response is issued for it.
REQ-032 All ready outputs SHALL be 0 while in reset.

Structure
REQ-040 AXI response codes (OKAY, EXOKAY, SLVERR, DECERR) SHALL be localparams in shared package axi4_pkg.
REQ-041 Range check and index calculation SHALL be one function in axi4_pkg, reused by the write and read paths.
REQ-042 Sub-module axil_wr_ch SHALL contain the AW/W holding registers and B logic; reads stay in the top.
REQ-043 The array SHALL infer distributed or block RAM; no vendor primitives.

Verification
REQ-050 AW and W in the same cycle: 0x0010_0000 = 0xDEAD_BEEF -> bvalid 2 cycles later, OKAY; read of 0x0010_0000 -> 0xDEAD_BEEF, rvalid 1 cycle after AR handshake.
REQ-051 W 3 cycles before AW, wstrb=4'b0010, data 0x0000_AB00, over 0x1111_1111 -> read returns 0x1111_AB11.
REQ-052 Write to 0x0010_1000 with DEPTH=1024 -> bresp 2'b10; read there -> rdata 0, rresp 2'b10; word 0 unchanged.
REQ-053 bready held low 20 cycles after a write; second AW/W accepted; second write commits only after first B handshake; both B responses in order.
REQ-054 Read and write to 0x0010_0004 committing on the same edge (old 0x5, new 0x6) -> read returns 0x5; next read returns 0x6.
REQ-055 axilite_rstb pulsed low while rvalid is high and rready is low -> rvalid 0 immediately; no stale R after release; array keeps its data.
